// File: rtl/elastic_mesh_fabric.sv
// elastic_mesh_fabric
//   Valid/stop interconnect joining a ROWS x COLS grid of PEs in a 4-neighbour
//   mesh. Every directed neighbour link owns a LINK_DEPTH-entry elastic FIFO.
//   Stop is derived from registered FIFO state only, so back-pressure never
//   ripples combinationally from one PE to the next.
//
//   Flat port index p = ((i*COLS + j)*4 + d), d: 0=north 1=south 2=west 3=east.
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     pe_out_*        PE(i,j) output toward d (data/valid in, stop out)
//     pe_in_*         PE(i,j) input from d   (data/valid out, stop in)
//     clear_stats     synchronous clear of stall_cycles (wins over increment)
//     fabric_busy     registered: some link FIFO will be non-empty
//     stall_cycles    saturating count of cycles with any link valid && stop
//
//   Build option: define ELASTIC_MESH_TORUS_EN to add wrap-around links on
//   every dimension of size >= 2. Undefined gives a plain mesh whose boundary
//   ports are dead ends (input never valid, output always stopped).

// Per-link FIFO. No fall-through: a beat written at edge N is visible from
// cycle N+1. DEPTH may be any value >= 2; pointers wrap explicitly.
module elastic_mesh_link_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_valid,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_stop,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data,
   input  logic                  pop_stop,
   output logic                  nonempty_next
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_nxt;
   logic                  push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   // Full stop comes from the registered count only: a full link refuses a
   // push even in a cycle where the consumer is draining it.
   assign push_stop     = (count == CW'(DEPTH));
   assign push          = push_valid && !push_stop;
   assign pop_valid     = (count != '0);
   assign pop           = pop_valid && !pop_stop;
   assign pop_data      = pop_valid ? mem[rd_ptr] : '0;
   assign nonempty_next = (count_nxt != '0);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CW'(1);
      else if (!push && pop)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count_nxt;
      end
   end

   // Storage needs no reset: empty entries are masked on the read side.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end
endmodule

module elastic_mesh_fabric #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int LINK_DEPTH = 2,
   parameter int STAT_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [ROWS*COLS*4*DATA_WIDTH-1:0] pe_out_data,
   input  logic [ROWS*COLS*4-1:0]            pe_out_valid,
   output logic [ROWS*COLS*4-1:0]            pe_out_stop,
   output logic [ROWS*COLS*4*DATA_WIDTH-1:0] pe_in_data,
   output logic [ROWS*COLS*4-1:0]            pe_in_valid,
   input  logic [ROWS*COLS*4-1:0]            pe_in_stop,
   input  logic                             clear_stats,
   output logic                             fabric_busy,
   output logic [STAT_WIDTH-1:0]            stall_cycles
);
   localparam int NP = ROWS * COLS * 4;

`ifdef ELASTIC_MESH_TORUS_EN
   localparam bit TORUS = 1'b1;
`else
   localparam bit TORUS = 1'b0;
`endif

   // Links are symmetric: output d of PE(i,j) exists exactly when input d of
   // PE(i,j) exists, so one predicate serves both directions.
   function automatic bit has_nb(input int i, input int j, input int d);
      case (d)
         0:       return (i > 0)        || (TORUS && ROWS >= 2);
         1:       return (i < ROWS - 1) || (TORUS && ROWS >= 2);
         2:       return (j > 0)        || (TORUS && COLS >= 2);
         default: return (j < COLS - 1) || (TORUS && COLS >= 2);
      endcase
   endfunction

   // Flat index of the neighbour's input port facing back toward PE(i,j).
   function automatic int nb_port(input int i, input int j, input int d);
      int ni, nj;
      ni = i;
      nj = j;
      case (d)
         0:       ni = (i == 0)        ? ROWS - 1 : i - 1;
         1:       ni = (i == ROWS - 1) ? 0        : i + 1;
         2:       nj = (j == 0)        ? COLS - 1 : j - 1;
         default: nj = (j == COLS - 1) ? 0        : j + 1;
      endcase
      return (ni * COLS + nj) * 4 + (d ^ 1);
   endfunction

   logic [NP-1:0] link_busy;
   logic          any_stall;

   for (genvar p = 0; p < NP; p++) begin : g_link
      localparam int I = p / (COLS * 4);
      localparam int J = (p / 4) % COLS;
      localparam int D = p % 4;

      if (has_nb(I, J, D)) begin : g_fifo
         localparam int Q = nb_port(I, J, D);
         elastic_mesh_link_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINK_DEPTH)
         ) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .push_valid    (pe_out_valid[p]),
            .push_data     (pe_out_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .push_stop     (pe_out_stop[p]),
            .pop_valid     (pe_in_valid[Q]),
            .pop_data      (pe_in_data[Q*DATA_WIDTH +: DATA_WIDTH]),
            .pop_stop      (pe_in_stop[Q]),
            .nonempty_next (link_busy[p])
         );
      end else begin : g_edge
         // Dead end: hold the producer forever so a misrouted beat stalls
         // visibly rather than vanishing.
         logic unused_edge;
         assign pe_out_stop[p]                          = 1'b1;
         assign pe_in_valid[p]                          = 1'b0;
         assign pe_in_data[p*DATA_WIDTH +: DATA_WIDTH]  = '0;
         assign link_busy[p]                            = 1'b0;
         assign unused_edge = pe_out_valid[p] ^ pe_in_stop[p]
                              ^ (^pe_out_data[p*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   assign any_stall = |(pe_in_valid & pe_in_stop);

   always_ff @(posedge clk) begin
      if (reset) begin
         fabric_busy  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         fabric_busy <= |link_busy;
         if (clear_stats)
            stall_cycles <= '0;
         else if (any_stall && !(&stall_cycles))
            stall_cycles <= stall_cycles + STAT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_elastic_mesh_fabric.sv
// Scoreboard bench for elastic_mesh_fabric on a 3x3 grid, LINK_DEPTH=2.
// Drivers push expected beats when a producer beat is accepted; a negedge
// monitor pops and compares whenever a watched consumer port takes a beat.
module tb_elastic_mesh_fabric;
   localparam int DW = 32;
   localparam int R  = 3;
   localparam int C  = 3;
   localparam int NP = R * C * 4;
   localparam int SRC_E = 3;   // PE(0,0) east
   localparam int MON_E = 6;   // PE(0,1) west input
   localparam int SRC_T = 4;   // PE(0,1) north
   localparam int MON_T = 29;  // PE(2,1) south input

`ifdef ELASTIC_MESH_TORUS_EN
   localparam bit TORUS = 1'b1;
`else
   localparam bit TORUS = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] d;
      int            cyc;
      bit            exact;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NP*DW-1:0]     pe_out_data;
   logic [NP-1:0]        pe_out_valid;
   logic [NP-1:0]        pe_out_stop;
   logic [NP*DW-1:0]     pe_in_data;
   logic [NP-1:0]        pe_in_valid;
   logic [NP-1:0]        pe_in_stop;
   logic                 clear_stats;
   logic                 fabric_busy;
   logic [31:0]          stall_cycles;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   sb_en  = 1'b1;
   exp_t q_e[$];
   exp_t q_t[$];

   elastic_mesh_fabric #(
      .DATA_WIDTH (DW),
      .ROWS       (R),
      .COLS       (C),
      .LINK_DEPTH (2),
      .STAT_WIDTH (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pe_out_data  (pe_out_data),
      .pe_out_valid (pe_out_valid),
      .pe_out_stop  (pe_out_stop),
      .pe_in_data   (pe_in_data),
      .pe_in_valid  (pe_in_valid),
      .pe_in_stop   (pe_in_stop),
      .clear_stats  (clear_stats),
      .fabric_busy  (fabric_busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Ports with no neighbour: these must hold stop high.
   function automatic logic [NP-1:0] edge_mask();
      logic [NP-1:0] m;
      m = '0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            for (int d = 0; d < 4; d++) begin
               bit conn;
               case (d)
                  0:       conn = (i > 0)     || TORUS;
                  1:       conn = (i < R - 1) || TORUS;
                  2:       conn = (j > 0)     || TORUS;
                  default: conn = (j < C - 1) || TORUS;
               endcase
               m[(i*C + j)*4 + d] = !conn;
            end
      return m;
   endfunction

   // Called #1 after a posedge; returns #1 after the posedge that took the beat.
   task automatic send(input int p, input logic [DW-1:0] d, input bit exact);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      pe_out_valid[p]        = 1'b1;
      pe_out_data[p*DW +: DW] = d;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (!pe_out_stop[p]) ok = 1'b1;
      end
      if (!ok) chk("send_timeout", 64'(d), 64'hFFFF_FFFF);
      else if (sb_en) begin
         e.d     = d;
         e.cyc   = cyc + 1;
         e.exact = exact;
         if (p == SRC_T) q_t.push_back(e);
         else            q_e.push_back(e);
      end
      @(posedge clk);
      #1;
      pe_out_valid[p]        = 1'b0;
      pe_out_data[p*DW +: DW] = '0;
   endtask

   // Monitor: a beat transfers at the next edge when valid && !stop now.
   always @(negedge clk) begin
      if (!reset) begin
         if (pe_in_valid[MON_E] && !pe_in_stop[MON_E]) begin
            if (q_e.size() == 0) chk("unexpected_beat_e", 64'(pe_in_data[MON_E*DW +: DW]), 64'hFFFF_FFFF_FFFF);
            else begin
               exp_t e;
               e = q_e.pop_front();
               chk("data_e", 64'(pe_in_data[MON_E*DW +: DW]), 64'(e.d));
               if (e.exact) chk("latency_e", 64'(cyc), 64'(e.cyc));
            end
         end
         if (pe_in_valid[MON_T] && !pe_in_stop[MON_T]) begin
            if (q_t.size() == 0) chk("unexpected_beat_t", 64'(pe_in_data[MON_T*DW +: DW]), 64'hFFFF_FFFF_FFFF);
            else begin
               exp_t e;
               e = q_t.pop_front();
               chk("data_t", 64'(pe_in_data[MON_T*DW +: DW]), 64'(e.d));
               if (e.exact) chk("latency_t", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset        = 1'b1;
      pe_out_data  = '0;
      pe_out_valid = '0;
      pe_in_stop   = '0;
      clear_stats  = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_in_valid", 64'(pe_in_valid), 64'd0);
      chk("rst_in_data_zero", 64'(pe_in_data == '0), 64'd1);
      chk("rst_out_stop", 64'(pe_out_stop), 64'(edge_mask()));
      chk("rst_busy", 64'(fabric_busy), 64'd0);
      chk("rst_stall", 64'(stall_cycles), 64'd0);

      // Back-to-back beats, consumer never stops: order kept, 1/cycle, N+1
      send(SRC_E, 32'hA, 1'b1);
      chk("busy_set", 64'(fabric_busy), 64'd1);
      send(SRC_E, 32'hB, 1'b1);
      send(SRC_E, 32'hC, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_idle", 64'(fabric_busy), 64'd0);
      chk("drain_1", 64'(q_e.size()), 64'd0);

      // Consumer held: link fills, 3rd beat held, then full + pop same cycle
      pe_in_stop[MON_E] = 1'b1;
      fork
         begin
            send(SRC_E, 32'h1111_0001, 1'b0);
            send(SRC_E, 32'h1111_0002, 1'b0);
            send(SRC_E, 32'h1111_0003, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("full_stop", 64'(pe_out_stop[SRC_E]), 64'd1);
            @(posedge clk);
            #1 clear_stats = 1'b1;
            @(posedge clk);
            #1 clear_stats = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("stall_count", 64'(stall_cycles), 64'd4);
            pe_in_stop[MON_E] = 1'b0;
            @(negedge clk);
            chk("full_pop_no_push", 64'(pe_out_stop[SRC_E]), 64'd1);
            chk("full_pop_valid", 64'(pe_in_valid[MON_E]), 64'd1);
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("stall_hold", 64'(stall_cycles), 64'd4);
      chk("drain_2", 64'(q_e.size()), 64'd0);
      chk("busy_idle_2", 64'(fabric_busy), 64'd0);

`ifndef ELASTIC_MESH_TORUS_EN
      // Boundary port: PE(0,0) north is a dead end
      pe_out_valid[0]     = 1'b1;
      pe_out_data[0 +: DW] = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("edge_out_stop", 64'(pe_out_stop[0]), 64'd1);
         chk("edge_in_valid", 64'(pe_in_valid[0]), 64'd0);
         chk("edge_in_data", 64'(pe_in_data[0 +: DW]), 64'd0);
      end
      chk("edge_busy", 64'(fabric_busy), 64'd0);
      @(posedge clk);
      #1;
      pe_out_valid[0]     = 1'b0;
      pe_out_data[0 +: DW] = '0;
`else
      // Wrap link: PE(0,1) north lands on PE(2,1) south input
      send(SRC_T, 32'h55, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("torus_drain", 64'(q_t.size()), 64'd0);
`endif

      // Reset with two beats in flight
      pe_in_stop[MON_E] = 1'b1;
      sb_en = 1'b0;
      send(SRC_E, 32'h0000_0011, 1'b0);
      send(SRC_E, 32'h0000_0022, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("mid_rst_in_valid", 64'(pe_in_valid), 64'd0);
      chk("mid_rst_in_data_zero", 64'(pe_in_data == '0), 64'd1);
      chk("mid_rst_out_stop", 64'(pe_out_stop), 64'(edge_mask()));
      chk("mid_rst_busy", 64'(fabric_busy), 64'd0);
      chk("mid_rst_stall", 64'(stall_cycles), 64'd0);
      pe_in_stop[MON_E] = 1'b0;
      sb_en = 1'b1;
      send(SRC_E, 32'h0000_0077, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_drain", 64'(q_e.size()), 64'd0);
      chk("final_q_t", 64'(q_t.size()), 64'd0);
      chk("final_busy", 64'(fabric_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
